regwb_retire: RTL and testbench

REGWB_RETIRE -- requirements
Module: regwb_retire

---
 rtl/regwb_retire.sv | 161 ++++++++++++++++
 tb/tb_regwb_retire.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regwb_retire.sv
// regwb_retire: in-order retire queue for register writebacks.
// Tracks up to four outstanding register writes, each expecting its result
// from either the ALU path or main memory, and retires them strictly in
// issue order onto a single register-file write port.
// Build option: define REGWB_BYPASS_EN to drive the writeback port
// combinationally in the retire cycle instead of one cycle later.
module regwb_retire (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_from_mem,
  input  logic [2:0]  issue_adr,
  input  logic        flush_decode,
  input  logic        memory_waiting,
  input  logic        alu_result_valid,
  input  logic [15:0] alu_result,
  input  logic        mem_result_valid,
  input  logic [15:0] mem_result,
  output logic        wb_en,
  output logic [2:0]  wb_adr,
  output logic [15:0] wb_data,
  output logic [23:0] pending_cnt,
  output logic        issue_stall,
  output logic        order_err
);

  // Each entry is {adr[2:0], from_mem}
  logic [3:0]  fifo_reg [4];
  logic [1:0]  wr_ptr_reg;
  logic [1:0]  rd_ptr_reg;
  logic [2:0]  occ_reg;
  logic        order_err_reg;

  logic        empty;
  logic        full;
  logic        push;
  logic        retire;
  logic        bad_result;
  logic        mem_strobe;
  logic [2:0]  head_adr;
  logic        head_from_mem;
  logic [15:0] retire_data;

  assign empty         = (occ_reg == 3'd0);
  assign full          = (occ_reg == 3'd4);
  assign head_adr      = fifo_reg[rd_ptr_reg][3:1];
  assign head_from_mem = fifo_reg[rd_ptr_reg][0];

  // A memory result only counts as delivered once memory has stopped waiting.
  assign mem_strobe = mem_result_valid & ~memory_waiting;

  // Full is decided from registered occupancy only, so a same-cycle retire
  // never frees a slot for the issue presented alongside it.
  assign push = issue_valid & ~flush_decode & ~full;

  // Retire/order-error decision for the head entry
  always_comb begin
    retire      = 1'b0;
    bad_result  = 1'b0;
    retire_data = alu_result;
    if (empty) begin
      bad_result = alu_result_valid | mem_strobe;
    end else if (head_from_mem) begin
      retire      = mem_strobe;
      bad_result  = alu_result_valid;
      retire_data = mem_result;
    end else begin
      retire      = alu_result_valid;
      bad_result  = mem_strobe;
      retire_data = alu_result;
    end
  end

  // Queue storage: no reset needed, occupancy qualifies every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr_reg] <= {issue_adr, issue_from_mem};
    end
  end

  // Pointers, occupancy and the sticky order-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= 2'd0;
      rd_ptr_reg    <= 2'd0;
      occ_reg       <= 3'd0;
      order_err_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (retire) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      if (push && !retire) begin
        occ_reg <= occ_reg + 3'd1;
      end else if (!push && retire) begin
        occ_reg <= occ_reg - 3'd1;
      end
      if (bad_result) begin
        order_err_reg <= 1'b1;
      end
    end
  end

  assign issue_stall = full;
  assign order_err   = order_err_reg;

  // Per-register outstanding-write counters
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
      logic [2:0] cnt_reg;
      logic       inc;
      logic       dec;
      assign inc = push && (issue_adr == 3'(gi));
      assign dec = retire && (head_adr == 3'(gi));
      // Count up on issue, down on retire; both together cancel
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= 3'd0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + 3'd1;
        end else if (!inc && dec) begin
          cnt_reg <= cnt_reg - 3'd1;
        end
      end
      assign pending_cnt[3*gi +: 3] = cnt_reg;
    end
  endgenerate

`ifdef REGWB_BYPASS_EN
  // Zero-latency writeback: the port reflects the retire of this cycle
  assign wb_en   = retire & ~reset;
  assign wb_adr  = wb_en ? head_adr : 3'd0;
  assign wb_data = wb_en ? retire_data : 16'd0;
`else
  logic        wb_en_reg;
  logic [2:0]  wb_adr_reg;
  logic [15:0] wb_data_reg;

  // One-cycle registered writeback; address/data hold between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_reg   <= 1'b0;
      wb_adr_reg  <= 3'd0;
      wb_data_reg <= 16'd0;
    end else begin
      wb_en_reg <= retire;
      if (retire) begin
        wb_adr_reg  <= head_adr;
        wb_data_reg <= retire_data;
      end
    end
  end

  assign wb_en   = wb_en_reg;
  assign wb_adr  = wb_adr_reg;
  assign wb_data = wb_data_reg;
`endif

endmodule

// File: tb/tb_regwb_retire.sv
// tb_regwb_retire: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the retire ordering rules.
module tb_regwb_retire;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_from_mem;
  logic [2:0]  issue_adr;
  logic        flush_decode;
  logic        memory_waiting;
  logic        alu_result_valid;
  logic [15:0] alu_result;
  logic        mem_result_valid;
  logic [15:0] mem_result;
  logic        wb_en;
  logic [2:0]  wb_adr;
  logic [15:0] wb_data;
  logic [23:0] pending_cnt;
  logic        issue_stall;
  logic        order_err;

  regwb_retire dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_from_mem   (issue_from_mem),
    .issue_adr        (issue_adr),
    .flush_decode     (flush_decode),
    .memory_waiting   (memory_waiting),
    .alu_result_valid (alu_result_valid),
    .alu_result       (alu_result),
    .mem_result_valid (mem_result_valid),
    .mem_result       (mem_result),
    .wb_en            (wb_en),
    .wb_adr           (wb_adr),
    .wb_data          (wb_data),
    .pending_cnt      (pending_cnt),
    .issue_stall      (issue_stall),
    .order_err        (order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] adr;
    logic       from_mem;
  } ent_t;

  ent_t model_q[$];
  logic model_err = 1'b0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pending();
    logic [23:0] v;
    v = '0;
    foreach (model_q[i]) v[3*model_q[i].adr +: 3] = v[3*model_q[i].adr +: 3] + 3'd1;
    return v;
  endfunction

  // One clock cycle: drive inputs, predict, advance, compare
  task automatic cycle(input logic rst, input logic iv, input logic ifm, input logic [2:0] ia,
                       input logic fl, input logic mw, input logic av, input logic [15:0] ad,
                       input logic mv, input logic [15:0] md);
    logic        ret;
    logic        acc;
    logic        bad;
    logic        mem_ok;
    logic [2:0]  r_adr;
    logic [15:0] r_data;
    reset = rst; issue_valid = iv; issue_from_mem = ifm; issue_adr = ia;
    flush_decode = fl; memory_waiting = mw; alu_result_valid = av; alu_result = ad;
    mem_result_valid = mv; mem_result = md;
    #1;
    mem_ok = mv && !mw;
    ret = 1'b0; bad = 1'b0; r_adr = 3'd0; r_data = 16'd0;
    if (model_q.size() == 0) begin
      bad = av || mem_ok;
    end else begin
      r_adr = model_q[0].adr;
      if (model_q[0].from_mem) begin
        ret = mem_ok; bad = av; r_data = md;
      end else begin
        ret = av; bad = mem_ok; r_data = ad;
      end
    end
    if (rst) ret = 1'b0;
    acc = iv && !fl && (model_q.size() < 4);
`ifdef REGWB_BYPASS_EN
    check("wb_en", 32'(wb_en), 32'(ret));
    if (ret) begin
      check("wb_adr", 32'(wb_adr), 32'(r_adr));
      check("wb_data", 32'(wb_data), 32'(r_data));
      $display("write r%0d = %04h", r_adr, r_data);
    end
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if (ret) void'(model_q.pop_front());
      if (acc) model_q.push_back('{adr: ia, from_mem: ifm});
      if (bad) model_err = 1'b1;
    end
`ifndef REGWB_BYPASS_EN
    check("wb_en", 32'(wb_en), 32'(ret));
    if (ret) begin
      check("wb_adr", 32'(wb_adr), 32'(r_adr));
      check("wb_data", 32'(wb_data), 32'(r_data));
      $display("write r%0d = %04h", r_adr, r_data);
    end
`endif
    check("issue_stall", 32'(issue_stall), 32'(model_q.size() == 4));
    check("pending_cnt", 32'(pending_cnt), 32'(model_pending()));
    check("order_err", 32'(order_err), 32'(model_err));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 3'd0, 0, 0, 0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    // Reset while an issue and results are presented: reset must win
    cycle(1, 1, 0, 3'd4, 0, 0, 1, 16'hAAAA, 1, 16'h5555);
    do_reset();
    check("reset_wb_adr", 32'(wb_adr), 32'd0);
    check("reset_wb_data", 32'(wb_data), 32'd0);
    check("reset_pending", 32'(pending_cnt), 32'd0);

    // r3 ALU write, result next cycle
    cycle(0, 1, 0, 3'd3, 0, 0, 0, 16'h0, 0, 16'h0);
    check("r3_pending_1", 32'(pending_cnt[11:9]), 32'd1);
    cycle(0, 0, 0, 3'd0, 0, 0, 1, 16'h1234, 0, 16'h0);
    check("r3_pending_0", 32'(pending_cnt[11:9]), 32'd0);
    idle();

    // r5 memory write held off by memory_waiting
    cycle(0, 1, 1, 3'd5, 0, 0, 0, 16'h0, 0, 16'h0);
    repeat (3) cycle(0, 0, 0, 3'd0, 0, 1, 0, 16'h0, 1, 16'hDEAD);
    cycle(0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 1, 16'hBEEF);
    idle();

    // Fill with four ALU writes, then a fifth issue alongside a retire
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 3'(i), 0, 0, 0, 16'h0, 0, 16'h0);
    check("full_stall", 32'(issue_stall), 32'd1);
    cycle(0, 1, 0, 3'd4, 0, 0, 1, 16'h0F0F, 0, 16'h0);
    check("after_drop_stall", 32'(issue_stall), 32'd0);
    check("dropped_r4", 32'(pending_cnt[14:12]), 32'd0);
    do_reset();

    // Memory entry at head receives an ALU result
    cycle(0, 1, 1, 3'd1, 0, 0, 0, 16'h0, 0, 16'h0);
    cycle(0, 0, 0, 3'd0, 0, 0, 1, 16'h7777, 0, 16'h0);
    check("order_err_set", 32'(order_err), 32'd1);
    idle();
    idle();
    do_reset();
    check("order_err_clr", 32'(order_err), 32'd0);

    // Flushed issue, then same-register issue and retire together
    cycle(0, 1, 0, 3'd2, 1, 0, 0, 16'h0, 0, 16'h0);
    cycle(0, 1, 0, 3'd2, 0, 0, 0, 16'h0, 0, 16'h0);
    cycle(0, 1, 0, 3'd2, 0, 0, 1, 16'h2222, 0, 16'h0);
    check("r2_unchanged", 32'(pending_cnt[8:6]), 32'd1);
    cycle(0, 0, 0, 3'd0, 0, 0, 1, 16'h3333, 0, 16'h0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 60), $urandom_range(1),
            3'($urandom_range(7)), ($urandom_range(99) < 10), ($urandom_range(99) < 30),
            ($urandom_range(99) < 30), 16'($urandom), ($urandom_range(99) < 35), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
